sal_apb_cfg_master: RTL and testbench
=====================================

Name: sal_apb_cfg_master

Overview:
- APB requester that programs the controller's configuration register block at boot or on software request.
- Walks a table of NUM_REGS (address, data) entries. For each entry it issues one APB write, then optionally reads the register back and compares it.
- Sits between the boot/CSR sequencer and the APB completer side of the configuration block.
- Reports done or error, with the failing entry index.

Parameters:
- ADDR_W, 12, APB address width
- DATA_W, 32, APB data width
- NUM_REGS, 10, table entries to program (>=1)
- VERIFY, 1, 1 = read back and compare each entry after its write; 0 = write only
- TIMEOUT, 255, max ACCESS cycles waiting for pready before error (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  1-cycle pulse; begins a table walk when idle
- busy  out  1  walk in progress
- done  out  1  sticky; walk completed with no error
- error  out  1  sticky; walk aborted
- err_code  out  2  0 none, 1 pslverr, 2 readback mismatch, 3 timeout
- err_idx  out  $clog2(NUM_REGS)+1  entry index that failed
- tbl_idx  out  $clog2(NUM_REGS)+1  current table index (combinational lookup request)
- tbl_addr  in  ADDR_W  address for tbl_idx, valid same cycle
- tbl_data  in  DATA_W  write data for tbl_idx, valid same cycle
- paddr  out  ADDR_W  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB error

Behaviour:
- Reset: state IDLE; all outputs 0 (busy, done, error, err_code, err_idx, tbl_idx, paddr, psel, penable, pwrite, pwdata).
- States: IDLE, W_SETUP, W_ACCESS, R_SETUP, R_ACCESS, FINISH.
- IDLE:
  - start=1 clears done, error, err_code and err_idx, sets tbl_idx=0, sets busy=1, and goes to W_SETUP.
- W_SETUP:
  - On entry, paddr/pwdata are registered from tbl_addr/tbl_data.
  - Drives psel=1, penable=0, pwrite=1 for exactly one cycle, then goes to W_ACCESS.
- W_ACCESS:
  - Drives psel=1, penable=1. paddr, pwrite and pwdata are held stable.
  - Transfer completes in the cycle pready=1. Minimum write latency is 2 cycles.
  - pslverr=1 at completion -> error, code 1.
  - Otherwise, if VERIFY=1, go to R_SETUP; else go to next entry.
- R_SETUP / R_ACCESS:
  - Same phasing as the write, with the same paddr and pwrite=0.
  - At completion, pslverr=1 -> error code 1.
  - prdata != registered pwdata -> error code 2.
  - Otherwise go to next entry.
- Next entry:
  - If tbl_idx == NUM_REGS-1, go to FINISH.
  - Otherwise tbl_idx+1, then W_SETUP. The back-to-back SETUP follows ACCESS with no idle cycle.
- Timeout:
  - A counter resets on entering each ACCESS state and increments per ACCESS cycle with pready=0.
  - Reaching TIMEOUT -> error code 3.
- Error path:
  - Deasserts psel and penable next cycle.
  - Latches err_idx=tbl_idx, sets error=1, then goes to FINISH.
- FINISH:
  - busy=0.
  - Sets done=1 only if no error was recorded.
  - Returns to IDLE.
- start while busy: ignored.
- start in the same cycle as FINISH: ignored; it is accepted only in IDLE.
- Async reset mid-transfer: psel and penable drop immediately; no partial state is kept.
- psel/penable are never asserted outside W_*/R_*.
- penable is asserted only in the cycle after SETUP.

Decomposition:
- Shared package sal_cfg_pkg:
  - state enum
  - err_code localparams (ERR_NONE, ERR_SLVERR, ERR_MISMATCH, ERR_TIMEOUT)
  - timing-register address map constants (T_RCD..T_RTW offsets) that boot tables use
- One natural sub-module: sal_apb_timeout_cnt (loadable down-counter with expiry flag).

Test Plan:
- NUM_REGS=3, VERIFY=0, completer with pready=1 always -> 6 APB cycles with SETUP/ACCESS alternating; paddr follows table 0x000, 0x004, 0x008; done=1 two cycles after the last ACCESS; error=0.
- VERIFY=1, completer echoes writes, pready with 2 wait states -> each ACCESS lasts 3 cycles; reads return the written data (e.g. 0x5 for T_RCD); done=1.
- Completer returns pslverr on entry 1 write -> error=1, err_code=1, err_idx=1; no transfers to entry 2; done=0.
- Completer read of entry 2 returns 0xDEAD vs written 0x0000000C -> err_code=2, err_idx=2.
- pready held 0 with TIMEOUT=4 -> psel drops after 4 ACCESS cycles; err_code=3.
- Reset asserted during W_ACCESS of entry 1, then a new start -> psel=0 immediately on reset; new walk restarts at tbl_idx=0; a second start while busy has no effect.

Source files
------------

// File: rtl/sal_cfg_pkg.sv
// Shared definitions for the APB configuration master and the boot tables
// that feed it: FSM states, error codes and the timing-register map.
package sal_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_ACCESS,
    R_SETUP,
    R_ACCESS,
    FINISH
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_SLVERR   = 2'd1;
  localparam logic [1:0] ERR_MISMATCH = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  // Byte offsets of the DRAM timing registers inside the config block
  localparam int T_RCD = 'h000;
  localparam int T_RP  = 'h004;
  localparam int T_RAS = 'h008;
  localparam int T_RC  = 'h00C;
  localparam int T_WR  = 'h010;
  localparam int T_RTW = 'h014;

endpackage

// File: rtl/sal_apb_timeout_cnt.sv
// Loadable down-counter that flags when an APB ACCESS phase has used up its
// wait budget. Loaded in SETUP with TIMEOUT-1, it reaches zero on the
// TIMEOUT-th ACCESS cycle that sees pready low.
module sal_apb_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Reload at every SETUP, count down once per stalled ACCESS cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(TIMEOUT - 1);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/sal_apb_cfg_master.sv
// APB requester that walks a (address, data) table, writing each entry and
// optionally reading it back for comparison. Reports sticky done/error with
// the failing entry index.
module sal_apb_cfg_master
  import sal_cfg_pkg::*;
#(
  parameter int  ADDR_W   = 12,
  parameter int  DATA_W   = 32,
  parameter int  NUM_REGS = 10,
  parameter int  VERIFY   = 1,
  parameter int  TIMEOUT  = 255,
  localparam int IW       = $clog2(NUM_REGS) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [IW-1:0]     err_idx,
  output logic [IW-1:0]     tbl_idx,
  input  logic [ADDR_W-1:0] tbl_addr,
  input  logic [DATA_W-1:0] tbl_data,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  state_t        state, state_next;
  logic [IW-1:0] idx_q;
  logic          load_entry, start_walk, set_err, advance;
  logic          tmo_load, tmo_dec, tmo_expired;
  logic [1:0]    err_next;
  logic          last_entry;

  assign last_entry = (idx_q == IW'(NUM_REGS - 1));

  sal_apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (tmo_load),
    .dec     (tmo_dec),
    .expired (tmo_expired)
  );

  // Next state, APB phase outputs and the table lookup index. tbl_idx points
  // at the entry about to be captured so its address/data arrive in time to
  // be registered on entry to W_SETUP.
  always_comb begin
    state_next = state;
    tbl_idx    = idx_q;
    load_entry = 1'b0;
    start_walk = 1'b0;
    set_err    = 1'b0;
    err_next   = ERR_NONE;
    advance    = 1'b0;
    tmo_load   = 1'b0;
    tmo_dec    = 1'b0;
    busy       = 1'b0;
    psel       = 1'b0;
    penable    = 1'b0;
    pwrite     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          start_walk = 1'b1;
          tbl_idx    = '0;
          load_entry = 1'b1;
          state_next = W_SETUP;
        end
      end
      W_SETUP: begin
        busy       = 1'b1;
        psel       = 1'b1;
        pwrite     = 1'b1;
        tmo_load   = 1'b1;
        state_next = W_ACCESS;
      end
      W_ACCESS: begin
        busy    = 1'b1;
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b1;
        if (pready) begin
          if (pslverr) begin
            set_err  = 1'b1;
            err_next = ERR_SLVERR;
          end else if (VERIFY != 0) begin
            state_next = R_SETUP;
          end else begin
            advance = 1'b1;
          end
        end else if (tmo_expired) begin
          set_err  = 1'b1;
          err_next = ERR_TIMEOUT;
        end else begin
          tmo_dec = 1'b1;
        end
      end
      R_SETUP: begin
        busy       = 1'b1;
        psel       = 1'b1;
        tmo_load   = 1'b1;
        state_next = R_ACCESS;
      end
      R_ACCESS: begin
        busy    = 1'b1;
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          if (pslverr) begin
            set_err  = 1'b1;
            err_next = ERR_SLVERR;
          end else if (prdata != pwdata) begin
            set_err  = 1'b1;
            err_next = ERR_MISMATCH;
          end else begin
            advance = 1'b1;
          end
        end else if (tmo_expired) begin
          set_err  = 1'b1;
          err_next = ERR_TIMEOUT;
        end else begin
          tmo_dec = 1'b1;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (set_err) begin
      state_next = FINISH;
    end
    if (advance) begin
      if (last_entry) begin
        state_next = FINISH;
      end else begin
        tbl_idx    = idx_q + IW'(1);
        load_entry = 1'b1;
        state_next = W_SETUP;
      end
    end
  end

  // FSM state register; reset drops psel/penable immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Entry capture for the APB address/data and sticky walk status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      paddr    <= '0;
      pwdata   <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_code <= ERR_NONE;
      err_idx  <= '0;
    end else begin
      if (load_entry) begin
        idx_q  <= tbl_idx;
        paddr  <= tbl_addr;
        pwdata <= tbl_data;
      end
      if (start_walk) begin
        done     <= 1'b0;
        error    <= 1'b0;
        err_code <= ERR_NONE;
        err_idx  <= '0;
      end
      if (set_err) begin
        error    <= 1'b1;
        err_code <= err_next;
        err_idx  <= idx_q;
      end
      if (state == FINISH) begin
        done <= ~error;
      end
    end
  end

endmodule

// File: tb/tb_sal_apb_cfg_master.sv
// Self-checking bench: an APB completer with configurable wait states and
// fault injection, plus a transaction-level model of what a table walk must
// produce (transfer list, status, and walk length in cycles).
`timescale 1ns/1ps
module tb_sal_apb_cfg_master;
  import sal_cfg_pkg::*;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 3;
  localparam int VERIFY   = 1;
  localparam int TIMEOUT  = 4;
  localparam int IW       = $clog2(NUM_REGS) + 1;
  localparam int MAXX     = 2 * NUM_REGS;
  localparam int XW       = 1 + ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy, done, error;
  logic [1:0]        err_code;
  logic [IW-1:0]     err_idx, tbl_idx;
  logic [ADDR_W-1:0] tbl_addr, paddr;
  logic [DATA_W-1:0] tbl_data, pwdata, prdata;
  logic              psel, penable, pwrite, pready, pslverr;

  logic [ADDR_W-1:0] taddr [NUM_REGS];
  logic [DATA_W-1:0] tdata [NUM_REGS];
  logic [DATA_W-1:0] mem [0:4095];
  logic [XW-1:0]     obs_q [$];
  int                wait_tbl [MAXX];
  int                inj_kind, inj_xfer, xfer;
  int                n_checks = 0;
  int                n_fail   = 0;

  sal_apb_cfg_master #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .VERIFY   (VERIFY),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_code (err_code),
    .err_idx  (err_idx),
    .tbl_idx  (tbl_idx),
    .tbl_addr (tbl_addr),
    .tbl_data (tbl_data),
    .paddr    (paddr),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr)
  );

  always #5 clk = ~clk;

  // Combinational boot table answering the DUT's lookup index
  always_comb begin
    tbl_addr = '0;
    tbl_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (tbl_idx == IW'(i)) begin
        tbl_addr = taddr[i];
        tbl_data = tdata[i];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] corrupt(input logic [DATA_W-1:0] v);
    return (v == 32'hDEAD) ? ~v : 32'hDEAD;
  endfunction

  // APB completer: decides pready for the coming edge at each negedge and
  // logs every transfer it completes
  initial begin
    int  acc_wait;
    bit  prev_setup, prev_access;
    acc_wait = 0; prev_setup = 0; prev_access = 0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    forever begin
      @(negedge clk);
      if (psel && penable) begin
        if (!prev_access) checkOutput("setup_before_access", 64'(prev_setup), 64'd1);
        if (xfer < MAXX && acc_wait < wait_tbl[xfer]) begin
          pready = 1'b0; pslverr = 1'b0; acc_wait++;
        end else begin
          pready   = 1'b1;
          acc_wait = 0;
          pslverr  = (inj_kind == 1 && inj_xfer == xfer);
          if (pwrite) begin
            mem[paddr] = pwdata;
            prdata = '0;
            obs_q.push_back({1'b1, paddr, pwdata});
          end else begin
            prdata = (inj_kind == 2 && inj_xfer == xfer) ? corrupt(mem[paddr]) : mem[paddr];
            obs_q.push_back({1'b0, paddr, {DATA_W{1'b0}}});
          end
          xfer++;
        end
      end else begin
        pready = 1'b0; pslverr = 1'b0; acc_wait = 0;
      end
      prev_setup  = psel && !penable;
      prev_access = psel && penable;
    end
  end

  // One table walk. kind: 0 none, 1 pslverr, 2 readback mismatch, 3 timeout,
  // injected at transfer number ixfer. extra: cycle of a stray start pulse
  // (0 none, <0 random). fixed_wait <0 picks random wait states 0..3.
  task automatic applyStimulus(input int kind, input int ixfer, input int extra, input int fixed_wait);
    logic [XW-1:0] exp_q [$];
    int tot, ecode, eidx, lat, cnt, xtra;
    bit fin;
    for (int k = 0; k < MAXX; k++) wait_tbl[k] = (fixed_wait < 0) ? int'($urandom_range(0, 3)) : fixed_wait;
    if (kind == 3) wait_tbl[ixfer] = 1000;
    inj_kind = kind; inj_xfer = ixfer;
    tot = 0; ecode = 0; eidx = 0;
    for (int e = 0; e < NUM_REGS && ecode == 0; e++) begin
      for (int ph = 0; ph < 2 && ecode == 0; ph++) begin
        int k;
        k = 2 * e + ph;
        if (kind == 3 && ixfer == k) begin
          tot += 1 + TIMEOUT; ecode = int'(ERR_TIMEOUT); eidx = e;
        end else begin
          if (ph == 0) exp_q.push_back({1'b1, taddr[e], tdata[e]});
          else         exp_q.push_back({1'b0, taddr[e], {DATA_W{1'b0}}});
          tot += 2 + wait_tbl[k];
          if ((kind == 1 || (kind == 2 && ph == 1)) && ixfer == k) begin
            ecode = kind; eidx = e;
          end
        end
      end
    end
    lat  = tot + ((ecode == 0) ? 1 : 0);
    xtra = (extra < 0) ? int'($urandom_range(1, tot)) : extra;
    obs_q.delete(); xfer = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checkOutput("first_setup", {busy, psel, penable, pwrite}, 4'b1101);
    checkOutput("first_paddr", paddr, taddr[0]);
    cnt = 0; fin = 0;
    while (!fin && cnt < 300) begin
      @(negedge clk);
      cnt++;
      start = (cnt == xtra);
      fin   = done || error;
    end
    checkOutput("walk_completes", 64'(fin), 64'd1);
    checkOutput("walk_cycles", cnt, lat);
    @(negedge clk); start = 1'b0;
    checkOutput("done", done, (ecode == 0));
    checkOutput("error", error, (ecode != 0));
    checkOutput("err_code", err_code, ecode);
    checkOutput("err_idx", err_idx, eidx);
    repeat (2) @(negedge clk);
    checkOutput("idle_after_walk", {busy, psel, penable}, 3'b000);
    checkOutput("xfer_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      checkOutput($sformatf("xfer%0d", i), obs_q[i], exp_q[i]);
  endtask

  // Directed scenarios, an asynchronous reset mid-walk, then random walks
  initial begin
    int n;
    rst = 1'b1; start = 1'b0; xfer = 0; inj_kind = 0; inj_xfer = 0;
    for (int k = 0; k < MAXX; k++) wait_tbl[k] = 0;
    taddr[0] = ADDR_W'(T_RCD); taddr[1] = ADDR_W'(T_RP); taddr[2] = ADDR_W'(T_RAS);
    tdata[0] = 32'h5; tdata[1] = 32'h7; tdata[2] = 32'hC;
    repeat (2) @(negedge clk);
    checkOutput("rst_status", {busy, done, error, err_code, err_idx, tbl_idx}, 0);
    checkOutput("rst_bus", {psel, penable, pwrite}, 0);
    checkOutput("rst_paddr", paddr, 0);
    checkOutput("rst_pwdata", pwdata, 0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 2);
    applyStimulus(1, 2, 0, 0);
    applyStimulus(2, 5, 0, 1);
    applyStimulus(3, 1, 0, 0);
    applyStimulus(0, 0, 3, 0);
    applyStimulus(0, 0, 12, 0);

    for (int k = 0; k < MAXX; k++) wait_tbl[k] = 2;
    inj_kind = 0; xfer = 0; obs_q.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!(psel && penable && pwrite && tbl_idx == IW'(1)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach_entry1_access", 64'(psel && penable && pwrite && tbl_idx == IW'(1)), 64'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_mid_bus", {psel, penable, busy}, 3'b000);
    checkOutput("rst_mid_idx", tbl_idx, 0);
    @(negedge clk); rst = 1'b0;
    applyStimulus(0, 0, 0, -1);

    repeat (20) begin
      int r, x;
      for (int e = 0; e < NUM_REGS; e++) tdata[e] = $urandom;
      r = int'($urandom_range(0, 3));
      x = (r == 2) ? 2 * int'($urandom_range(0, NUM_REGS - 1)) + 1 : int'($urandom_range(0, MAXX - 1));
      applyStimulus(r, x, ($urandom_range(0, 1) == 1) ? -1 : 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Backstop so a stuck run still terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
